fg_config_loader: RTL



---
 rtl/fg_config_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fg_config_loader.sv
// fg_config_loader: SPI mode-0 slave that fills a shadow config word and commits it atomically
// to the active generator bus, also owning output enable and active-word read-back.
module fg_config_loader #(
  parameter int CONFIG_REG_BITWIDTH = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           spi_sclk_i,
  input  logic                           spi_csn_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           outputEnable_o,
  output logic                           configUpdate_STRB_o,
  output logic                           frameError_o
);
  localparam int W = CONFIG_REG_BITWIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, WRITE, READ, HOLD} state_t;
  typedef enum logic [1:0] {A_NONE, A_COMMIT, A_OFF, A_ON} act_t;
  logic [SYNC_STAGES-1:0] sclk_q, csn_q, mosi_q;
  logic sclk_p_q, csn_p_q;
  logic sclk_s, csn_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
  state_t state_q, state_d;
  act_t act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-2:0] sh_q, sh_d;
  logic [W-1:0] shadow_q, shadow_d, cr_q, cr_d, rd_q, rd_d;
  logic oe_q, oe_d, strb_q, strb_d, ferr_q, ferr_d, miso_q, miso_d;
  logic [7:0] cmd;
  // CS synchronizer resets to "selected" so a frame already in progress at reset is never seen as a fresh fall
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_q <= '0;
      csn_q <= '0;
      mosi_q <= '0;
      sclk_p_q <= 1'b0;
      csn_p_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk_i};
      csn_q <= {csn_q[SYNC_STAGES-2:0], spi_csn_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_p_q <= sclk_s;
      csn_p_q <= csn_s;
    end
  end
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign csn_s = csn_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p_q;
  assign sclk_fall = ~sclk_s & sclk_p_q;
  assign cs_rise = csn_s & ~csn_p_q;
  assign cs_fall = ~csn_s & csn_p_q;
  assign cmd = {sh_q[6:0], mosi_s};
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    shadow_d = shadow_q;
    cr_d = cr_q;
    rd_d = rd_q;
    oe_d = oe_q;
    strb_d = 1'b0;
    ferr_d = 1'b0;
    miso_d = (state_q == READ) ? miso_q : 1'b0;
    if (state_q == WAIT_IDLE) begin
      if (csn_s) state_d = IDLE;
    end else if (cs_rise) begin
      state_d = IDLE;
      act_d = A_NONE;
      miso_d = 1'b0;
      ferr_d = (state_q == CMD) || (state_q == WRITE);
      if (state_q == HOLD) begin
        strb_d = act_q == A_COMMIT;
        cr_d = (act_q == A_COMMIT) ? shadow_q : cr_q;
        oe_d = (act_q == A_OFF) ? 1'b0 : (act_q == A_ON) ? 1'b1 : oe_q;
      end
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d = '0;
          act_d = A_NONE;
        end
        CMD: if (sclk_rise) begin
          sh_d = {sh_q[W-3:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(7)) begin
            cnt_d = '0;
            state_d = (cmd == 8'h01) ? WRITE : (cmd == 8'h03) ? READ : HOLD;
            act_d = (cmd == 8'h02) ? A_COMMIT : (cmd == 8'h10) ? A_OFF : (cmd == 8'h11) ? A_ON : A_NONE;
            rd_d = {cr_q[W-2:0], 1'b0};
            miso_d = (cmd == 8'h03) & cr_q[W-1];
          end
        end
        WRITE: if (sclk_rise) begin
          sh_d = {sh_q[W-3:0], mosi_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            shadow_d = {sh_q, mosi_s};
            state_d = HOLD;
          end
        end
        READ: begin
          // the falling edge closing the command byte must not advance past the MSB
          if (sclk_rise) cnt_d = CW'(1);
          if (sclk_fall && cnt_q != '0) begin
            miso_d = rd_q[W-1];
            rd_d = {rd_q[W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= WAIT_IDLE;
      act_q <= A_NONE;
      cnt_q <= '0;
      sh_q <= '0;
      shadow_q <= '0;
      cr_q <= '0;
      rd_q <= '0;
      oe_q <= 1'b0;
      strb_q <= 1'b0;
      ferr_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      shadow_q <= shadow_d;
      cr_q <= cr_d;
      rd_q <= rd_d;
      oe_q <= oe_d;
      strb_q <= strb_d;
      ferr_q <= ferr_d;
      miso_q <= miso_d;
    end
  end
  assign spi_miso_o = miso_q;
  assign CR_bus_o = cr_q;
  assign outputEnable_o = oe_q;
  assign configUpdate_STRB_o = strb_q;
  assign frameError_o = ferr_q;
endmodule
